// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA frame scanout path.
// Holds 640x480@60 timing constants, the pixel colour struct and the reset palette.
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Raster strobes carried down the read-latency pipeline; all active-high internally.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic in_fb;
    logic frame_start;
  } strobe_t;

  localparam rgb_t DEFAULT_PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters advanced on the pixel enable,
// plus the raw timing strobes decoded from the current counter values.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int FB_COLS   = 635,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output strobe_t    raw
);

  localparam int H_LEN = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == 10'(H_LEN - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 10'(V_LEN - 1)) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Sync windows are half-open [LO, HI) so H_SYNC/V_SYNC give the pulse width directly.
  always_comb begin
    raw             = '0;
    raw.active      = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    raw.hsync       = (h_cnt >= 10'(HS_LO)) && (h_cnt < 10'(HS_HI));
    raw.vsync       = (v_cnt >= 10'(VS_LO)) && (v_cnt < 10'(VS_HI));
    raw.in_fb       = (h_cnt < 10'(FB_COLS));
    raw.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_frame_scanout.sv
// Frame buffer read side: raster timing, FB addressing, latency alignment and VGA pin registers.
// Define VGA_PALETTE_EN to map pixel indices through a writable 16x24-bit palette instead of greyscale.
module vga_frame_scanout
  import vga_pkg::*;
#(
  parameter int DATA_SIZE  = 4,
  parameter int FB_COLS    = 635,
  parameter int FB_ROWS    = 480,
  parameter int RD_LATENCY = 1,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  output logic [8:0]           row,
  output logic [9:0]           column,
  input  logic [DATA_SIZE-1:0] fb_data,
`ifdef VGA_PALETTE_EN
  input  logic                 pal_we,
  input  logic [3:0]           pal_addr,
  input  logic [23:0]          pal_data,
`endif
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 frame_start
);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  strobe_t    raw;
  strobe_t    aligned;
  rgb_t       colour;
  rgb_t       rgb_q;

  vga_timing_counter #(
    .FB_COLS   (FB_COLS),
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .raw    (raw)
  );

  assign column = (h_cnt < 10'(FB_COLS)) ? h_cnt : '0;
  assign row    = (v_cnt < 10'(FB_ROWS)) ? v_cnt[8:0] : '0;

  // Delay the strobes by the frame buffer read latency so they line up with fb_data.
  generate
    if (RD_LATENCY == 0) begin : g_no_pipe
      assign aligned = raw;
    end else begin : g_pipe
      strobe_t stage [RD_LATENCY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
        end else if (pix_en) begin
          stage[0] <= raw;
          for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
        end
      end
      assign aligned = stage[RD_LATENCY-1];
    end
  endgenerate

`ifdef VGA_PALETTE_EN
  rgb_t palette [16];

  // Palette writes use the system clock directly so the CPU side need not know about pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) palette[i] <= DEFAULT_PALETTE[i];
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  assign colour = palette[fb_data[3:0]];
`else
  // Replicate the index MSB-first across 8 bits so full-scale index gives full-scale grey.
  always_comb begin
    colour = '0;
    for (int i = 0; i < 8; i++) begin
      colour.r[7-i] = fb_data[DATA_SIZE-1-(i % DATA_SIZE)];
    end
    colour.g = colour.r;
    colour.b = colour.r;
  end
`endif

  // frame_start drops on the very next clk so it is a single-cycle pulse even when pix_en is sparse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync       <= ~aligned.hsync;
        vsync       <= ~aligned.vsync;
        blank_n     <= aligned.active;
        rgb_q       <= (aligned.active && aligned.in_fb) ? colour : '0;
        frame_start <= aligned.frame_start;
      end
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Self-checking bench for vga_frame_scanout: full-size instances at read latency 0/1/3 and a
// shrunken-timing instance so whole frames fit in a short run. Define VGA_PALETTE_EN to test the palette.
module tb_vga_frame_scanout;

  localparam int N = 4;
  localparam int LAT  [N] = '{1, 0, 3, 2};
  localparam int HV   [N] = '{640, 640, 640, 16};
  localparam int HF   [N] = '{16, 16, 16, 2};
  localparam int HS   [N] = '{96, 96, 96, 4};
  localparam int HB   [N] = '{48, 48, 48, 2};
  localparam int VV   [N] = '{480, 480, 480, 8};
  localparam int VF   [N] = '{10, 10, 10, 1};
  localparam int VS   [N] = '{2, 2, 2, 2};
  localparam int VB   [N] = '{33, 33, 33, 1};
  localparam int COLS [N] = '{635, 635, 635, 13};
  localparam int ROWS [N] = '{480, 480, 480, 6};

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] col;
    logic [8:0] row;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [8:0] row         [N];
  logic [9:0] column      [N];
  logic [3:0] fb_data     [N];
  logic       hsync       [N];
  logic       vsync       [N];
  logic       blank_n     [N];
  logic       frame_start [N];
  logic [7:0] vga_r       [N];
  logic [7:0] vga_g       [N];
  logic [7:0] vga_b       [N];
`ifdef VGA_PALETTE_EN
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
`endif

  int  ticks;
  bit  ticked;
  int  n_checks;
  int  n_fail;
  logic [23:0] ref_pal [N][16];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      logic [3:0] hist [4];

      vga_frame_scanout #(
        .DATA_SIZE (4), .FB_COLS (COLS[gi]), .FB_ROWS (ROWS[gi]), .RD_LATENCY (LAT[gi]),
        .H_VISIBLE (HV[gi]), .H_FRONT (HF[gi]), .H_SYNC (HS[gi]), .H_BACK (HB[gi]),
        .V_VISIBLE (VV[gi]), .V_FRONT (VF[gi]), .V_SYNC (VS[gi]), .V_BACK (VB[gi])
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .row         (row[gi]),
        .column      (column[gi]),
        .fb_data     (fb_data[gi]),
`ifdef VGA_PALETTE_EN
        .pal_we      (gi == 0 ? pal_we : 1'b0),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
`endif
        .hsync       (hsync[gi]),
        .vsync       (vsync[gi]),
        .blank_n     (blank_n[gi]),
        .vga_r       (vga_r[gi]),
        .vga_g       (vga_g[gi]),
        .vga_b       (vga_b[gi]),
        .frame_start (frame_start[gi])
      );

      // Frame buffer stand-in: returns COLUMN[3:0] after LAT pixel-enable ticks.
      always @(posedge clk) begin
        if (pix_en) begin
          hist[0] <= column[gi][3:0];
          for (int j = 1; j < 4; j++) hist[j] <= hist[j-1];
        end
      end

      if (LAT[gi] == 0) begin : g_l0
        assign fb_data[gi] = column[gi][3:0];
      end else begin : g_ln
        assign fb_data[gi] = hist[LAT[gi]-1];
      end
    end
  endgenerate

  task automatic reset_ref_pal();
    logic [23:0] cga [16];
    cga = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA, 24'hAA0000, 24'hAA00AA,
            24'hAA5500, 24'hAAAAAA, 24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
            24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
    for (int i = 0; i < N; i++)
      for (int c = 0; c < 16; c++) ref_pal[i][c] = cga[c];
  endtask

  // Reference: after k ticks the counters sit at raster position k and pins show position k-1-LAT.
  function automatic exp_t model(input int i, input int k, input bit tk);
    exp_t e;
    int ht, vt, p, h, v, ch, cv;
    logic [7:0] lvl;
    ht = HV[i] + HF[i] + HS[i] + HB[i];
    vt = VV[i] + VF[i] + VS[i] + VB[i];
    ch = k % ht;
    cv = (k / ht) % vt;
    e = '0;
    e.col = (ch < COLS[i]) ? 10'(ch) : 10'd0;
    e.row = (cv < ROWS[i]) ? 9'(cv) : 9'd0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    p = k - 1 - LAT[i];
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      e.hs = !(h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]);
      e.vs = !(v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]);
      e.bl = (h < HV[i]) && (v < VV[i]);
      e.fs = tk && (h == 0) && (v == 0);
      if (e.bl && h < COLS[i]) begin
`ifdef VGA_PALETTE_EN
        {e.r, e.g, e.b} = ref_pal[i][h % 16];
`else
        lvl = 8'((h % 16) * 17);
        e.r = lvl;
        e.g = lvl;
        e.b = lvl;
`endif
      end
    end
    return e;
  endfunction

  function automatic bit next_en();
    if (pix_en) return ($urandom_range(0, 3) == 0);
    return ($urandom_range(0, 4) != 0);
  endfunction

  // Inputs change at negedge; the DUT samples at posedge; outputs are observed at the next negedge.
  task automatic advance(input bit en);
    pix_en = en;
    @(posedge clk);
    if (rst) begin
      ticks  = 0;
      ticked = 1'b0;
      reset_ref_pal();
    end else begin
      ticked = en;
      if (en) ticks++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (3) advance(1'($urandom_range(0, 1)));
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({hsync[i], vsync[i], blank_n[i], frame_start[i]} !== 4'b1100 ||
          {vga_r[i], vga_g[i], vga_b[i]} !== 24'h0 || row[i] !== 9'd0 || column[i] !== 10'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_values inst%0d: got hs/vs/bl/fs=%b%b%b%b rgb=%h row=%0d col=%0d, want 1100 rgb=0 row=0 col=0",
                 i, hsync[i], vsync[i], blank_n[i], frame_start[i], {vga_r[i], vga_g[i], vga_b[i]}, row[i], column[i]);
      end
    end
    rst = 1'b0;
    advance(1'b0);
    advance(1'b1);
    for (int i = 0; i < N; i++) begin
      e = model(i, ticks, ticked);
      n_checks++;
      if ({row[i], column[i], hsync[i], vsync[i], blank_n[i], frame_start[i], vga_r[i]} !==
          {e.row, e.col, e.hs, e.vs, e.bl, e.fs, e.r}) begin
        n_fail++;
        $display("[TB] FAIL first_tick inst%0d: got row=%0d col=%0d hs/vs/bl/fs=%b%b%b%b r=%h want row=%0d col=%0d %b%b%b%b r=%h",
                 i, row[i], column[i], hsync[i], vsync[i], blank_n[i], frame_start[i], vga_r[i],
                 e.row, e.col, e.hs, e.vs, e.bl, e.fs, e.r);
      end
    end
  endtask

  task automatic test_pixel_data();
    exp_t e;
    int p;
    logic [7:0] want5;
`ifdef VGA_PALETTE_EN
    want5 = 8'hAA;
`else
    want5 = 8'h55;
`endif
    for (int it = 0; it < 4000 && ticks < 300; it++) begin
      advance(next_en());
      for (int i = 0; i < N; i++) begin
        e = model(i, ticks, ticked);
        n_checks++;
        if ({blank_n[i], vga_r[i], vga_g[i], vga_b[i], row[i], column[i]} !==
            {e.bl, e.r, e.g, e.b, e.row, e.col}) begin
          n_fail++;
          $display("[TB] FAIL pixel inst%0d tick %0d: got bl=%b rgb=%h%h%h row=%0d col=%0d want bl=%b rgb=%h%h%h row=%0d col=%0d",
                   i, ticks, blank_n[i], vga_r[i], vga_g[i], vga_b[i], row[i], column[i],
                   e.bl, e.r, e.g, e.b, e.row, e.col);
        end
        p = ticks - 1 - LAT[i];
        if (ticked && p == 5) begin
          n_checks++;
          if (blank_n[i] !== 1'b1 || vga_r[i] !== want5 || vga_b[i] !== want5) begin
            n_fail++;
            $display("[TB] FAIL pixel_x5 inst%0d: got bl=%b r=%h b=%h want bl=1 r=b=%h",
                     i, blank_n[i], vga_r[i], vga_b[i], want5);
          end
        end
      end
    end
    if (ticks < 300) begin
      n_fail++;
      $display("[TB] FAIL pixel_budget: reached tick %0d, required 300", ticks);
    end
  endtask

  task automatic test_fb_edge();
    int p;
    for (int it = 0; it < 6000 && ticks < 700; it++) begin
      advance(next_en());
      for (int i = 0; i < 3; i++) begin
        p = ticks - 1 - LAT[i];
        if (ticked && p >= 635 && p <= 640) begin
          n_checks++;
          if (blank_n[i] !== (p < 640) || {vga_r[i], vga_g[i], vga_b[i]} !== 24'h0) begin
            n_fail++;
            $display("[TB] FAIL fb_edge inst%0d x=%0d: got bl=%b rgb=%h want bl=%b rgb=000000",
                     i, p, blank_n[i], {vga_r[i], vga_g[i], vga_b[i]}, (p < 640));
          end
        end
      end
    end
  endtask

  task automatic test_sync_timing();
    localparam int T = 1700;
    exp_t e;
    int p, ht, frm, want;
    int hs_low [N];
    int vs_low [N];
    int fs_cnt [N];
    int last_fs;
    rst = 1'b1;
    advance(1'b1);
    rst = 1'b0;
    last_fs = -1;
    for (int i = 0; i < N; i++) begin
      hs_low[i] = 0;
      vs_low[i] = 0;
      fs_cnt[i] = 0;
    end
    for (int it = 0; it < 20000 && ticks < T; it++) begin
      advance(next_en());
      for (int i = 0; i < N; i++) begin
        e = model(i, ticks, ticked);
        n_checks++;
        if ({hsync[i], vsync[i], frame_start[i], blank_n[i]} !== {e.hs, e.vs, e.fs, e.bl}) begin
          n_fail++;
          $display("[TB] FAIL sync inst%0d tick %0d: got hs/vs/fs/bl=%b%b%b%b want %b%b%b%b",
                   i, ticks, hsync[i], vsync[i], frame_start[i], blank_n[i], e.hs, e.vs, e.fs, e.bl);
        end
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        frm = ht * (VV[i] + VF[i] + VS[i] + VB[i]);
        p = ticks - 1 - LAT[i];
        if (ticked && p >= 0 && p < ht && hsync[i] === 1'b0) hs_low[i]++;
        if (ticked && p >= 0 && p < frm && vsync[i] === 1'b0) vs_low[i]++;
        if (frame_start[i] === 1'b1) fs_cnt[i]++;
      end
      if (frame_start[3] === 1'b1) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (ticks - last_fs != 288) begin
            n_fail++;
            $display("[TB] FAIL frame_period: got %0d ticks between pulses, want 288", ticks - last_fs);
          end
        end
        last_fs = ticks;
      end
    end
    for (int i = 0; i < N; i++) begin
      ht = HV[i] + HF[i] + HS[i] + HB[i];
      frm = ht * (VV[i] + VF[i] + VS[i] + VB[i]);
      n_checks++;
      if (hs_low[i] != HS[i]) begin
        n_fail++;
        $display("[TB] FAIL hsync_width inst%0d: got %0d low ticks, want %0d", i, hs_low[i], HS[i]);
      end
      want = (T - 1 - LAT[i]) / frm + 1;
      n_checks++;
      if (fs_cnt[i] != want) begin
        n_fail++;
        $display("[TB] FAIL frame_start_count inst%0d: got %0d, want %0d", i, fs_cnt[i], want);
      end
    end
    n_checks++;
    if (vs_low[3] != VS[3] * 24) begin
      n_fail++;
      $display("[TB] FAIL vsync_width: got %0d low ticks, want %0d", vs_low[3], VS[3] * 24);
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    rst = 1'b1;
    advance(1'b0);
    rst = 1'b0;
    for (int it = 0; it < 12000 && ticks < 1100; it++) advance(next_en());
    n_checks++;
    if (column[0] !== 10'd300 || row[0] !== 9'd1) begin
      n_fail++;
      $display("[TB] FAIL midframe_position: got row=%0d col=%0d want row=1 col=300", row[0], column[0]);
    end
    rst = 1'b1;
    advance(1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({hsync[i], vsync[i], blank_n[i], frame_start[i]} !== 4'b1100 ||
          row[i] !== 9'd0 || column[i] !== 10'd0) begin
        n_fail++;
        $display("[TB] FAIL midframe_reset inst%0d: got hs/vs/bl/fs=%b%b%b%b row=%0d col=%0d want 1100 row=0 col=0",
                 i, hsync[i], vsync[i], blank_n[i], frame_start[i], row[i], column[i]);
      end
    end
    for (int it = 0; it < 10000 && ticks < 800; it++) begin
      advance(next_en());
      for (int i = 0; i < N; i++) begin
        e = model(i, ticks, ticked);
        n_checks++;
        if ({hsync[i], vsync[i], blank_n[i], column[i]} !== {e.hs, e.vs, e.bl, e.col}) begin
          n_fail++;
          $display("[TB] FAIL after_reset inst%0d tick %0d: got hs/vs/bl=%b%b%b col=%0d want %b%b%b col=%0d",
                   i, ticks, hsync[i], vsync[i], blank_n[i], column[i], e.hs, e.vs, e.bl, e.col);
        end
      end
    end
  endtask

`ifdef VGA_PALETTE_EN
  task automatic test_palette();
    exp_t e;
    int target;
    for (int it = 0; it < 10000 && (ticks % 800) != 700; it++) advance(next_en());
    pal_addr = 4'd3;
    pal_data = 24'h123456;
    pal_we   = 1'b1;
    advance(1'b0);
    pal_we   = 1'b0;
    ref_pal[0][3] = 24'h123456;
    target = ticks - 700 + 800 + 3 + 1 + LAT[0];
    for (int it = 0; it < 10000 && ticks < target; it++) begin
      advance(next_en());
      for (int i = 0; i < N; i++) begin
        e = model(i, ticks, ticked);
        n_checks++;
        if ({vga_r[i], vga_g[i], vga_b[i]} !== {e.r, e.g, e.b}) begin
          n_fail++;
          $display("[TB] FAIL palette_run inst%0d tick %0d: got rgb=%h%h%h want %h%h%h",
                   i, ticks, vga_r[i], vga_g[i], vga_b[i], e.r, e.g, e.b);
        end
      end
    end
    n_checks++;
    if ({vga_r[0], vga_g[0], vga_b[0]} !== 24'h123456 || blank_n[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL palette_write: got rgb=%h%h%h bl=%b want 123456 bl=1",
               vga_r[0], vga_g[0], vga_b[0], blank_n[0]);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    pix_en   = 1'b0;
    ticks    = 0;
    ticked   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    reset_ref_pal();
`ifdef VGA_PALETTE_EN
    pal_we   = 1'b0;
    pal_addr = '0;
    pal_data = '0;
`endif
    @(negedge clk);
    advance(1'b0);
    rst = 1'b0;
    repeat (50) advance(1'b1);
    $display("[TB] reset");
    test_reset();
    $display("[TB] pixel data / latency alignment");
    test_pixel_data();
    $display("[TB] frame buffer right edge");
    test_fb_edge();
    $display("[TB] sync timing");
    test_sync_timing();
    $display("[TB] reset mid-frame");
    test_reset_midframe();
`ifdef VGA_PALETTE_EN
    $display("[TB] palette write");
    test_palette();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
